uart_rx: RTL and testbench

Serial receive stage paired with the team's 8N1 UART transmitter. It decodes the transmitter's frame: start bit 0, eight data bits LSB first, stop bit 1, idle high. The block oversamples the line, re-times it, verifies start and stop bits, and presents each received byte in a one-deep holding register with empty, framing-error and overrun flags. It sits between the board serial input pin and the security-system controller, which unloads bytes with a single-cycle strobe.

---
 rtl/uart_rx_if.sv | 25 ++
 rtl/uart_rx.sv | 117 +++++++++++
 tb/tb_uart_rx.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Byte-side bus of the UART receiver: received byte, status flags and unload strobe.
// The receiver drives it through master; the consumer uses slave.
interface uart_rx_if;
    logic [7:0] rxdata;
    logic       rxempty;
    logic       rxframeerr;
    logic       rxoverrun;
    logic       uldrxdata;

    modport master (
        output rxdata,
        output rxempty,
        output rxframeerr,
        output rxoverrun,
        input  uldrxdata
    );

    modport slave (
        input  rxdata,
        input  rxempty,
        input  rxframeerr,
        input  rxoverrun,
        output uldrxdata
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 serial receiver: oversampled, re-timed line, start/stop checks,
// one-deep holding register with empty, framing-error and overrun flags.
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic     rxclk,
    input  logic     reset,
    input  logic     rxin,
    input  logic     rxenable,
    uart_rx_if.master bus
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] HALF = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] LAST = SW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAITHI
    } state_t;

    state_t        state;
    logic [SW-1:0] samplecnt;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          rxmeta;
    logic          rxsync;
    logic [7:0]    rxdata;
    logic          rxempty;
    logic          rxframeerr;
    logic          rxoverrun;

    assign bus.rxdata     = rxdata;
    assign bus.rxempty    = rxempty;
    assign bus.rxframeerr = rxframeerr;
    assign bus.rxoverrun  = rxoverrun;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            rxmeta <= 1'b1;
            rxsync <= 1'b1;
        end else begin
            rxmeta <= rxin;
            rxsync <= rxmeta;
        end
    end

    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            samplecnt  <= '0;
            bitcnt     <= '0;
            shreg      <= '0;
            rxdata     <= '0;
            rxempty    <= 1'b1;
            rxframeerr <= 1'b0;
            rxoverrun  <= 1'b0;
        end else begin
            if (bus.uldrxdata) begin
                rxempty    <= 1'b1;
                rxframeerr <= 1'b0;
                rxoverrun  <= 1'b0;
            end
            if (!rxenable) begin
                state     <= IDLE;
                samplecnt <= '0;
                bitcnt    <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        samplecnt <= '0;
                        if (!rxsync) state <= START;
                    end
                    START: begin
                        samplecnt <= samplecnt + 1'b1;
                        if (samplecnt == HALF) begin
                            samplecnt <= '0;
                            bitcnt    <= '0;
                            state     <= rxsync ? IDLE : DATA;
                        end
                    end
                    DATA: begin
                        samplecnt <= samplecnt + 1'b1;
                        if (samplecnt == LAST) begin
                            shreg[bitcnt] <= rxsync;
                            bitcnt        <= bitcnt + 1'b1;
                            if (bitcnt == 3'd7) state <= STOP;
                        end
                    end
                    STOP: begin
                        samplecnt <= samplecnt + 1'b1;
                        if (samplecnt == LAST) begin
                            if (rxsync) begin
                                // New byte wins over a same-cycle unload.
                                rxdata  <= shreg;
                                rxempty <= 1'b0;
                                if (!rxempty && !bus.uldrxdata) rxoverrun <= 1'b1;
                                state <= IDLE;
                            end else begin
                                rxframeerr <= 1'b1;
                                state      <= WAITHI;
                            end
                        end
                    end
                    WAITHI: begin
                        samplecnt <= '0;
                        if (rxsync) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Randomized frame bench for uart_rx against a transaction-level model
// of the holding register and its flags.
module tb_uart_rx;
    localparam int OS  = 16;
    localparam int BIT = 16;

    logic rxclk = 1'b0;
    logic reset;
    logic rxin;
    logic rxenable;

    uart_rx_if bus ();

    uart_rx #(.OVERSAMPLE(OS)) dut (
        .rxclk    (rxclk),
        .reset    (reset),
        .rxin     (rxin),
        .rxenable (rxenable),
        .bus      (bus.master)
    );

    always #5 rxclk = ~rxclk;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] m_data;
    logic       m_empty;
    logic       m_fe;
    logic       m_ov;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_data"}, 32'(bus.rxdata), 32'(m_data));
        check({tag, "_empty"}, 32'(bus.rxempty), 32'(m_empty));
        check({tag, "_ferr"}, 32'(bus.rxframeerr), 32'(m_fe));
        check({tag, "_ovr"}, 32'(bus.rxoverrun), 32'(m_ov));
    endtask

    task automatic model_reset();
        m_data  = 8'h00;
        m_empty = 1'b1;
        m_fe    = 1'b0;
        m_ov    = 1'b0;
    endtask

    task automatic model_unload();
        m_empty = 1'b1;
        m_fe    = 1'b0;
        m_ov    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge rxclk);
            rxin          = 1'b1;
            bus.uldrxdata = 1'b0;
        end
    endtask

    task automatic unload(input string tag);
        @(negedge rxclk);
        bus.uldrxdata = 1'b1;
        @(negedge rxclk);
        bus.uldrxdata = 1'b0;
        model_unload();
        check_all(tag);
    endtask

    // Start drives at negedge c=0; the stop sample takes effect at the
    // 155th rising edge after that, so c=154 is the last pre-update look.
    task automatic send_frame(input string tag, input logic [7:0] b,
                              input logic stopbit, input logic uld_stop);
        logic [9:0] f;
        f = {stopbit, b, 1'b0};
        for (int c = 0; c < 10 * BIT; c++) begin
            @(negedge rxclk);
            if (c == 154) begin
                check({tag, "_pre_empty"}, 32'(bus.rxempty), 32'(m_empty));
                check({tag, "_pre_data"}, 32'(bus.rxdata), 32'(m_data));
            end
            if (c == 155) begin
                if (uld_stop) model_unload();
                if (stopbit) begin
                    if (!m_empty) m_ov = 1'b1;
                    m_data  = b;
                    m_empty = 1'b0;
                end else begin
                    m_fe = 1'b1;
                end
                check_all(tag);
            end
            rxin          = f[c / BIT];
            bus.uldrxdata = uld_stop && (c == 154);
        end
    endtask

    task automatic hold_low(input int n);
        repeat (n) begin
            @(negedge rxclk);
            rxin = 1'b0;
        end
    endtask

    task automatic partial_frame();
        for (int c = 0; c < 3 * BIT + BIT + BIT / 2; c++) begin
            @(negedge rxclk);
            rxin = (c < BIT) ? 1'b0 : 1'b0;
        end
    endtask

    initial begin
        logic [7:0] b;
        logic       bad;
        logic       us;
        reset         = 1'b1;
        rxin          = 1'b1;
        rxenable      = 1'b1;
        bus.uldrxdata = 1'b0;
        model_reset();
        repeat (3) @(negedge rxclk);
        check_all("reset");
        reset = 1'b0;
        idle(5);

        send_frame("a5", 8'hA5, 1'b1, 1'b0);
        unload("a5_uld");

        hold_low(4);
        idle(30);
        check_all("glitch");
        send_frame("3c", 8'h3C, 1'b1, 1'b0);
        unload("3c_uld");

        send_frame("3c_bad", 8'h3C, 1'b0, 1'b0);
        hold_low(40);
        idle(4);
        check_all("break");
        send_frame("5a", 8'h5A, 1'b1, 1'b0);
        unload("5a_uld");

        send_frame("ov11", 8'h11, 1'b1, 1'b0);
        send_frame("ov22", 8'h22, 1'b1, 1'b0);
        unload("ov_uld");

        send_frame("us11", 8'h11, 1'b1, 1'b0);
        send_frame("us22", 8'h22, 1'b1, 1'b1);
        unload("us_uld");

        partial_frame();
        repeat (5) begin
            @(negedge rxclk);
            rxenable = 1'b0;
            rxin     = 1'b1;
        end
        @(negedge rxclk);
        rxenable = 1'b1;
        idle(30);
        check_all("en_abort");
        send_frame("en_00", 8'h00, 1'b1, 1'b0);
        unload("en_uld");

        send_frame("pre_rst", 8'h96, 1'b1, 1'b0);
        partial_frame();
        @(negedge rxclk);
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge rxclk);
        reset = 1'b0;
        rxin  = 1'b1;
        idle(10);
        send_frame("rst_00", 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            b   = 8'($urandom);
            bad = ($urandom_range(0, 4) == 0);
            us  = ($urandom_range(0, 3) == 0);
            send_frame("rnd", b, !bad, us);
            if (bad) begin
                hold_low($urandom_range(0, 40));
                idle(4);
            end else if ($urandom_range(0, 1) == 0) begin
                idle($urandom_range(0, 20));
            end
            if ($urandom_range(0, 2) == 0) unload("rnd_uld");
        end

        idle(5);
        check_all("final");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
